// File: rtl/round_counter.sv
// round_counter: parametrised up/down counter for the Simon game core.
// Tracks round number / sequence position, supports parallel load with clamping,
// wrap or saturate at the limits, limit pulses, and a registered two-digit BCD copy
// of the count for the score display. All state changes on the falling clock edge.

module round_counter #(
    parameter int unsigned WIDTH   = 5,
    parameter int unsigned MIN_VAL = 1,
    parameter int unsigned MAX_VAL = 31,
    parameter int unsigned WRAP    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             increment,
    input  logic             decrement,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             hit_max,
    output logic             hit_min,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_ones
);

    // One extra bit so +1 / compare never aliases at 2^WIDTH.
    localparam int unsigned XW = WIDTH + 1;

    localparam logic [XW-1:0]    MIN_X    = XW'(MIN_VAL);
    localparam logic [XW-1:0]    MAX_X    = XW'(MAX_VAL);
    localparam logic [WIDTH-1:0] MIN_W    = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_VAL);
    localparam logic [3:0]       MIN_TENS = 4'(MIN_VAL / 10);
    localparam logic [3:0]       MIN_ONES = 4'(MIN_VAL % 10);

    // Elaboration-time legality check; any bad combination stops the build.
    if (WIDTH < 2 || WIDTH > 7 || MIN_VAL >= MAX_VAL || MAX_VAL > (2 ** WIDTH) - 1 ||
        MAX_VAL > 99 || WRAP > 1) begin : g_param_check
        $error("round_counter: illegal parameter combination");
    end

    // Declaration initialisers give the power-up state (same as the reset state).
    logic [WIDTH-1:0] r_count    = MIN_W;
    logic             r_hit_max  = 1'b0;
    logic             r_hit_min  = 1'b0;
    logic [3:0]       r_bcd_tens = MIN_TENS;
    logic [3:0]       r_bcd_ones = MIN_ONES;

    logic [XW-1:0]    w_count_x;
    logic [XW-1:0]    w_load_x;
    logic [XW-1:0]    w_next_x;
    logic [7:0]       w_next_8;
    logic [WIDTH-1:0] w_next;
    logic             w_set_max;
    logic             w_set_min;
    logic [3:0]       w_next_tens;
    logic [3:0]       w_next_ones;

    assign w_count_x = {1'b0, r_count};
    assign w_load_x  = {1'b0, load_val};

    // Next-count and pulse decision: load > (increment XOR decrement) > hold.
    always_comb begin
        w_next_x  = w_count_x;
        w_set_max = 1'b0;
        w_set_min = 1'b0;
        if (load) begin
            if (w_load_x < MIN_X) begin
                w_next_x = MIN_X;
            end else if (w_load_x > MAX_X) begin
                w_next_x = MAX_X;
            end else begin
                w_next_x = w_load_x;
            end
        end else if (increment && !decrement) begin
            if (w_count_x >= MAX_X) begin
                w_set_max = 1'b1;
                w_next_x  = (WRAP != 0) ? MIN_X : MAX_X;
            end else begin
                w_next_x = w_count_x + XW'(1);
            end
        end else if (decrement && !increment) begin
            if (w_count_x <= MIN_X) begin
                w_set_min = 1'b1;
                w_next_x  = (WRAP != 0) ? MAX_X : MIN_X;
            end else begin
                w_next_x = w_count_x - XW'(1);
            end
        end
    end

    assign w_next = w_next_x[WIDTH-1:0];

    // BCD digits of the next value, so digits land on the same edge as the count.
    always_comb begin
        w_next_8    = 8'(w_next_x);
        w_next_tens = 4'(w_next_8 / 8'd10);
        w_next_ones = 4'(w_next_8 % 8'd10);
    end

    // State update on the falling edge; synchronous reset dominates everything.
    always_ff @(negedge clk) begin
        if (reset) begin
            r_count    <= MIN_W;
            r_hit_max  <= 1'b0;
            r_hit_min  <= 1'b0;
            r_bcd_tens <= MIN_TENS;
            r_bcd_ones <= MIN_ONES;
        end else begin
            r_count    <= w_next;
            r_hit_max  <= w_set_max;
            r_hit_min  <= w_set_min;
            r_bcd_tens <= w_next_tens;
            r_bcd_ones <= w_next_ones;
        end
    end

    // Outputs: limit flags are combinational on the current count.
    always_comb begin
        count    = r_count;
        at_max   = (r_count == MAX_W);
        at_min   = (r_count == MIN_W);
        hit_max  = r_hit_max;
        hit_min  = r_hit_min;
        bcd_tens = r_bcd_tens;
        bcd_ones = r_bcd_ones;
    end

endmodule
